bounce_sprites: RTL and testbench

Multi-ball sprite engine for the VGA demo: keeps position/velocity state for `NUM_BALLS` bouncing balls, advances their physics once per frame with a small serial update machine, and renders them as ring-plus-heart discs. It sits between `vga_sync` and the background colour mux. Its `o_hit`/`o_color` pair overrides the sky layer, while the grass and dirt layers still take priority.

---
 rtl/bounce_pkg.sv | 29 ++
 rtl/bounce_sprites_if.sv | 12 +
 rtl/ball_physics.sv | 37 +++
 rtl/bounce_sprites.sv | 157 +++++++++++++++
 tb/tb_bounce_sprites.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncing-ball sprite engine.
package bounce_pkg;
  localparam logic [5:0] COLOR_HEART    = 6'b11_00_00;
  localparam logic [5:0] COLOR_RING     = 6'b10_00_00;
  localparam logic [7:0] PULSE_MIN_R2   = 8'd9;
  localparam logic [7:0] PULSE_LO       = 8'd20;
  localparam logic [7:0] PULSE_HI       = 8'd200;
  localparam logic [7:0] PULSE_STEP     = 8'd10;
  localparam logic [7:0] HEART_R2_FIXED = 8'd144;

  // y and vel hold two's-complement values; signedness is applied where used
  typedef struct packed {
    logic [11:0] xq;
    logic        dir;
    logic [11:0] y;
    logic [7:0]  vel;
  } ball_state_t;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COMMIT} upd_state_t;

  function automatic ball_state_t ball_reset(input int i, input int spacing);
    ball_state_t s;
    s.xq  = 12'(i * spacing * 4);
    s.dir = ((i % 2) == 0);
    s.y   = '0;
    s.vel = 8'(21 - 2 * i);
    return s;
  endfunction
endpackage

// File: rtl/bounce_sprites_if.sv
// Pixel-position / frame-tick inputs and sprite outputs of the ball engine.
interface bounce_sprites_if;
  logic [9:0] i_hpos;
  logic [9:0] i_vpos;
  logic       i_frame_end;
  logic       o_hit;
  logic [5:0] o_color;
  logic       o_busy;

  modport master (output i_hpos, i_vpos, i_frame_end, input o_hit, o_color, o_busy);
  modport slave  (input i_hpos, i_vpos, i_frame_end, output o_hit, o_color, o_busy);
endinterface

// File: rtl/ball_physics.sv
// Combinational one-frame physics step for a single ball.
module ball_physics
  import bounce_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int SIZE       = 32,
  parameter int SPEED_X    = 9,
  parameter int BOUNCE_VEL = 19
) (
  input  ball_state_t cur,
  input  logic        ball_odd,
  output ball_state_t nxt
);
  logic [9:0]        px;
  logic signed [12:0] y13, nv13;
  logic              landing;

  assign px      = cur.xq[11:2];
  assign y13     = {cur.y[11], cur.y};
  assign nv13    = 13'd0 - {{5{cur.vel[7]}}, cur.vel};
  assign landing = cur.vel[7] && !cur.y[11] && (y13 <= nv13);

  always_comb begin
    nxt = cur;
    if (px >= 10'(H_RES - SIZE)) nxt.dir = 1'b0;
    else if (px == '0)           nxt.dir = 1'b1;
    // step follows the pre-update direction
    nxt.xq = cur.dir ? cur.xq + 12'(SPEED_X) : cur.xq - 12'(SPEED_X);
    if (landing) begin
      nxt.y   = '0;
      nxt.vel = 8'(BOUNCE_VEL) + {6'd0, px[1:0]} + {7'd0, ball_odd};
    end else begin
      nxt.y   = cur.y + {{4{cur.vel[7]}}, cur.vel};
      nxt.vel = cur.vel - 8'd1;
    end
  end
endmodule

// File: rtl/bounce_sprites.sv
// Multi-ball sprite engine: serial per-frame physics update plus disc renderer.
// BOUNCE_PULSE_EN enables the animated heart radius; otherwise it is fixed.
module bounce_sprites
  import bounce_pkg::*;
#(
  parameter int NUM_BALLS  = 4,
  parameter int H_RES      = 640,
  parameter int GROUND_Y   = 384,
  parameter int SIZE       = 32,
  parameter int SPEED_X    = 9,
  parameter int BOUNCE_VEL = 19,
  parameter int RING_R2    = 241
) (
  input logic            clk,
  input logic            reset,
  bounce_sprites_if.slave bus
);
  localparam int KW      = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam int SPACING = H_RES / NUM_BALLS;
  localparam int HALF    = SIZE / 2;

  ball_state_t ball  [NUM_BALLS];
  logic [9:0]  sh_px [NUM_BALLS];
  logic [10:0] sh_y  [NUM_BALLS];
  upd_state_t  state;
  logic [KW-1:0] k;
  logic        busy;
  ball_state_t phys_cur, phys_nxt;
  logic [7:0]  heart_r2;

`ifdef BOUNCE_PULSE_EN
  logic heart_grow;
`else
  assign heart_r2 = HEART_R2_FIXED;
`endif

  assign phys_cur   = ball[k];
  assign bus.o_busy = busy;

  ball_physics #(
    .H_RES(H_RES), .SIZE(SIZE), .SPEED_X(SPEED_X), .BOUNCE_VEL(BOUNCE_VEL)
  ) u_phys (
    .cur(phys_cur), .ball_odd(k[0]), .nxt(phys_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        ball[i]  <= ball_reset(i, SPACING);
        sh_px[i] <= 10'(i * SPACING);
        sh_y[i]  <= '0;
      end
      state <= S_IDLE;
      k     <= '0;
      busy  <= 1'b0;
`ifdef BOUNCE_PULSE_EN
      heart_r2   <= PULSE_MIN_R2;
      heart_grow <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.i_frame_end) begin
          state <= S_UPDATE;
          k     <= '0;
          busy  <= 1'b1;
        end
        S_UPDATE: begin
          ball[k] <= phys_nxt;
          if (k == KW'(NUM_BALLS - 1)) state <= S_COMMIT;
          else                          k     <= k + KW'(1);
        end
        S_COMMIT: begin
          for (int i = 0; i < NUM_BALLS; i++) begin
            sh_px[i] <= ball[i].xq[11:2];
            sh_y[i]  <= ball[i].y[10:0];
          end
`ifdef BOUNCE_PULSE_EN
          if (heart_grow) begin
            if (heart_r2 >= PULSE_HI) heart_grow <= 1'b0;
            else                      heart_r2   <= heart_r2 + PULSE_STEP;
          end else begin
            if (heart_r2 < PULSE_LO)  heart_grow <= 1'b1;
            else                      heart_r2   <= heart_r2 - PULSE_STEP;
          end
`endif
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-ball hit test against the shadow copy, all math at 11 bits
  logic [NUM_BALLS-1:0]      b_hit;
  logic [NUM_BALLS-1:0][5:0] b_col;
  logic [10:0] h11, v11;
  assign h11 = {1'b0, bus.i_hpos};
  assign v11 = {1'b0, bus.i_vpos};

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    logic [10:0] left, right, bot, top, dx2, dy2, d2;
    logic signed [4:0]  dx, dy;
    logic signed [10:0] dxe, dye;
    logic in_box, hit;
    logic [5:0] col;

    assign left   = {1'b0, sh_px[g]};
    assign right  = left + 11'(SIZE);
    assign bot    = 11'(GROUND_Y) - sh_y[g];
    assign top    = bot - 11'(SIZE);
    assign in_box = (h11 >= left) && (h11 < right) && (v11 >= top) && (v11 < bot);
    assign dx     = 5'(h11 - left - 11'(HALF));
    assign dy     = 5'(v11 - top - 11'(HALF));
    assign dxe    = 11'(dx);
    assign dye    = 11'(dy);
    assign dx2    = 11'(dxe * dxe);
    assign dy2    = 11'(dye * dye);
    assign d2     = dx2 + dy2;

    always_comb begin
      hit = 1'b0;
      col = '0;
      if (in_box) begin
        if (d2 < {3'd0, heart_r2}) begin
          hit = 1'b1; col = COLOR_HEART;
        end else if (d2 < 11'(RING_R2)) begin
          hit = 1'b1; col = COLOR_RING;
        end
      end
    end
    assign b_hit[g] = hit;
    assign b_col[g] = col;
  end

  logic       hit_n;
  logic [5:0] col_n;
  always_comb begin
    hit_n = 1'b0;
    col_n = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--)
      if (b_hit[i]) begin
        hit_n = 1'b1;
        col_n = b_col[i];
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.o_hit   <= 1'b0;
      bus.o_color <= '0;
    end else begin
      bus.o_hit   <= hit_n;
      bus.o_color <= col_n;
    end
  end
endmodule

// File: tb/tb_bounce_sprites.sv
// Directed self-checking bench for bounce_sprites (default build, fixed heart r2).
module tb_bounce_sprites;
  import bounce_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bounce_sprites_if bus();
  bounce_sprites_if bus2();

  bounce_sprites dut (.clk(clk), .reset(reset), .bus(bus));
  // Narrow screen so neighbouring balls overlap right out of reset
  bounce_sprites #(.H_RES(64)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  ball_state_t p_cur, p_nxt;
  logic        p_odd;
  ball_physics u_ref (.cur(p_cur), .ball_odd(p_odd), .nxt(p_nxt));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int h; int v; logic [6:0] exp; } pix_t;
  typedef struct { ball_state_t in; logic odd; ball_state_t exp; } phys_t;

  function automatic ball_state_t mk(input int xq, input bit dir, input int y, input int vel);
    ball_state_t s;
    s.xq = 12'(xq); s.dir = dir; s.y = 12'(y); s.vel = 8'(vel);
    return s;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    bus.i_frame_end = 1'b0; bus.i_hpos = 10'd700; bus.i_vpos = 10'd500;
    bus2.i_frame_end = 1'b0; bus2.i_hpos = 10'd700; bus2.i_vpos = 10'd500;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (dut.ball[1].xq[11:2] !== 10'd160) begin n_bad++; $display("FAIL reset_b1_px got %0d want 160", dut.ball[1].xq[11:2]); end
    n_cmp++; if (dut.ball[2].vel !== 8'd17) begin n_bad++; $display("FAIL reset_b2_vel got %0d want 17", dut.ball[2].vel); end
    n_cmp++; if (dut.ball[1].dir !== 1'b0 || dut.ball[0].dir !== 1'b1) begin n_bad++; $display("FAIL reset_dir got %b%b want 10", dut.ball[0].dir, dut.ball[1].dir); end
    n_cmp++; if (dut.sh_px[3] !== 10'd480) begin n_bad++; $display("FAIL reset_sh3_px got %0d want 480", dut.sh_px[3]); end
    n_cmp++; if (bus.o_hit !== 1'b0 || bus.o_color !== 6'd0) begin n_bad++; $display("FAIL reset_hit got %b/%0h want 0/0", bus.o_hit, bus.o_color); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_render;
    pix_t tbl[8];
    tbl = '{'{0, 368, 7'h00}, '{16, 368, 7'h70}, '{28, 368, 7'h60}, '{16, 383, 7'h60},
            '{16, 384, 7'h00}, '{16, 352, 7'h00}, '{28, 380, 7'h00}, '{176, 368, 7'h70}};
    @(negedge clk); bus.i_hpos = 10'd300; bus.i_vpos = 10'd368;
    @(negedge clk); bus.i_hpos = 10'd16;
    #1;
    n_cmp++; if (bus.o_hit !== 1'b0) begin n_bad++; $display("FAIL render_early got %b want 0", bus.o_hit); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.o_hit, bus.o_color} !== 7'h70) begin n_bad++; $display("FAIL render_latency got %0h want 70", {bus.o_hit, bus.o_color}); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.i_hpos = 10'(tbl[i].h); bus.i_vpos = 10'(tbl[i].v);
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.o_hit, bus.o_color} !== tbl[i].exp) begin
        n_bad++; $display("FAIL render_%0d (%0d,%0d) got %0h want %0h", i, tbl[i].h, tbl[i].v, {bus.o_hit, bus.o_color}, tbl[i].exp);
      end
    end
    @(negedge clk); bus.i_hpos = 10'd700; bus.i_vpos = 10'd500;
  endtask

  task automatic test_overlap;
    pix_t tbl[4];
    tbl = '{'{20, 368, 7'h70}, '{28, 368, 7'h60}, '{40, 368, 7'h70}, '{60, 368, 7'h60}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus2.i_hpos = 10'(tbl[i].h); bus2.i_vpos = 10'(tbl[i].v);
      @(posedge clk); #1;
      n_cmp++;
      if ({bus2.o_hit, bus2.o_color} !== tbl[i].exp) begin
        n_bad++; $display("FAIL overlap_%0d (%0d,%0d) got %0h want %0h", i, tbl[i].h, tbl[i].v, {bus2.o_hit, bus2.o_color}, tbl[i].exp);
      end
    end
  endtask

  task automatic test_frame;
    int cnt;
    @(negedge clk); bus.i_frame_end = 1'b1;
    @(negedge clk); bus.i_frame_end = 1'b0;
    cnt = 0;
    while (bus.o_busy === 1'b1 && cnt < 20) begin
      cnt++;
      if (cnt == 5) begin
        n_cmp++; if (dut.sh_px[0] !== 10'd0) begin n_bad++; $display("FAIL frame_early_commit got %0d want 0", dut.sh_px[0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (cnt !== 5) begin n_bad++; $display("FAIL frame_busy_cycles got %0d want 5", cnt); end
    n_cmp++; if (dut.sh_px[0] !== 10'd2) begin n_bad++; $display("FAIL frame_sh0_px got %0d want 2", dut.sh_px[0]); end
    n_cmp++; if (dut.ball[0] !== mk(9, 1, 21, 20)) begin n_bad++; $display("FAIL frame_b0 got xq=%0d y=%0d vel=%0d want 9/21/20", dut.ball[0].xq, dut.ball[0].y, dut.ball[0].vel); end
    n_cmp++; if (dut.ball[1] !== mk(631, 0, 19, 18)) begin n_bad++; $display("FAIL frame_b1 got xq=%0d y=%0d vel=%0d want 631/19/18", dut.ball[1].xq, dut.ball[1].y, dut.ball[1].vel); end
    n_cmp++; if (dut.sh_y[0] !== 11'd21) begin n_bad++; $display("FAIL frame_sh0_y got %0d want 21", dut.sh_y[0]); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); bus.i_frame_end = 1'b1;
    @(negedge clk); bus.i_frame_end = 1'b0;
    @(negedge clk); bus.i_frame_end = 1'b1;
    @(negedge clk); bus.i_frame_end = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (dut.ball[0] !== mk(18, 1, 41, 19)) begin n_bad++; $display("FAIL ignore_b0 got xq=%0d y=%0d vel=%0d want 18/41/19", dut.ball[0].xq, dut.ball[0].y, dut.ball[0].vel); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL ignore_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_physics;
    phys_t tbl[8];
    tbl[0] = '{mk(2432, 1, 50, 5),  1'b0, mk(2441, 0, 55, 4)};
    tbl[1] = '{mk(2441, 0, 55, 4),  1'b0, mk(2432, 0, 59, 3)};
    tbl[2] = '{mk(8, 1, 3, -4),     1'b0, mk(17, 1, 0, 21)};
    tbl[3] = '{mk(12, 1, 3, -4),    1'b1, mk(21, 1, 0, 23)};
    tbl[4] = '{mk(400, 1, 4, -4),   1'b0, mk(409, 1, 0, 19)};
    tbl[5] = '{mk(400, 1, 5, -4),   1'b0, mk(409, 1, 1, -5)};
    tbl[6] = '{mk(0, 0, 0, 0),      1'b0, mk(4087, 1, 0, -1)};
    tbl[7] = '{mk(400, 0, -2, -3),  1'b0, mk(391, 0, -5, -4)};
    for (int i = 0; i < 8; i++) begin
      p_cur = tbl[i].in; p_odd = tbl[i].odd;
      #1;
      n_cmp++;
      if (p_nxt !== tbl[i].exp) begin
        n_bad++;
        $display("FAIL phys_%0d got xq=%0h dir=%b y=%0h vel=%0h want xq=%0h dir=%b y=%0h vel=%0h", i,
                 p_nxt.xq, p_nxt.dir, p_nxt.y, p_nxt.vel, tbl[i].exp.xq, tbl[i].exp.dir, tbl[i].exp.y, tbl[i].exp.vel);
      end
    end
  endtask

  task automatic test_reset_mid_update;
    @(negedge clk); bus.i_frame_end = 1'b1;
    @(negedge clk); bus.i_frame_end = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b want 1", bus.o_busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (dut.ball[0] !== mk(0, 1, 0, 21)) begin n_bad++; $display("FAIL midrst_b0 got xq=%0d y=%0d vel=%0d want 0/0/21", dut.ball[0].xq, dut.ball[0].y, dut.ball[0].vel); end
    n_cmp++; if (dut.sh_px[0] !== 10'd0 || dut.sh_y[0] !== 11'd0) begin n_bad++; $display("FAIL midrst_shadow got %0d/%0d want 0/0", dut.sh_px[0], dut.sh_y[0]); end
    n_cmp++; if (bus.o_busy !== 1'b0 || dut.state !== S_IDLE) begin n_bad++; $display("FAIL midrst_fsm got busy=%b state=%0d want 0/0", bus.o_busy, dut.state); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    p_cur = '0; p_odd = 1'b0;
    test_reset();
    test_render();
    test_overlap();
    test_frame();
    test_back_to_back();
    test_physics();
    test_reset_mid_update();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
